// File: rtl/capture_sram_if.sv
// rtl/capture_sram_if.sv - Bus bundle between the capture SRAM and its host.
// Purpose: carries the read-only SRAM bus and the capture stream/control
//   signals so they can be passed as one port.
// Signals:
//   mem_addr_i     [7:2] word read address from the SRAM bus
//   mem_data_o     [31:0] registered read data
//   sample_i       [31:0] capture data word
//   sample_valid_i qualifies sample_i
//   arm_i          one-cycle pulse that starts a capture
//   trig_i         trigger level
//   busy_o         capture in progress (ARMED or TRIGGERED)
//   done_o         capture complete
//   trig_pos_o     [5:0] word address of the trigger sample
// Modports: master drives the inputs, slave is the capture block.
interface capture_sram_if;
  logic [7:2]  mem_addr_i;
  logic [31:0] mem_data_o;
  logic [31:0] sample_i;
  logic        sample_valid_i;
  logic        arm_i;
  logic        trig_i;
  logic        busy_o;
  logic        done_o;
  logic [5:0]  trig_pos_o;

  modport master (
    output mem_addr_i, sample_i, sample_valid_i, arm_i, trig_i,
    input  mem_data_o, busy_o, done_o, trig_pos_o
  );

  modport slave (
    input  mem_addr_i, sample_i, sample_valid_i, arm_i, trig_i,
    output mem_data_o, busy_o, done_o, trig_pos_o
  );
endinterface

// File: rtl/capture_sram.sv
// rtl/capture_sram.sv - Triggered sample capture into a 64x32 SRAM with a read port.
// Purpose: after arm_i, writes valid samples into a circular 64-word buffer;
//   the first valid sample with trig_i high marks the trigger, and capture
//   stops once POST_TRIG samples (trigger included) have been written.
//   The buffer is readable at any time with one cycle of latency.
// Ports:
//   clk_i  single clock
//   rst_i  synchronous active-high reset (does not clear memory)
//   bus    capture_sram_if.slave: SRAM read bus, sample stream, arm/trigger
//          control and busy/done/trig_pos status
module capture_sram #(
  parameter int unsigned POST_TRIG = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  capture_sram_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_TRIGGERED,
    ST_DONE
  } state_e;

  localparam logic [6:0] POST_TRIG_C = 7'(POST_TRIG);

  state_e      state_q, state_d;
  logic [5:0]  wr_ptr_q, wr_ptr_d;
  logic [6:0]  post_cnt_q, post_cnt_d;
  logic [5:0]  trig_pos_q, trig_pos_d;
  logic [31:0] mem_data_q;
  logic [31:0] mem_q [64];
  logic        wr_en;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= 6'd0;
      post_cnt_q <= 7'd0;
      trig_pos_q <= 6'd0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      post_cnt_q <= post_cnt_d;
      trig_pos_q <= trig_pos_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    post_cnt_d = post_cnt_q;
    trig_pos_d = trig_pos_q;
    wr_en      = 1'b0;

    if (bus.arm_i) begin
      // arm restarts from any state and suppresses the write of that cycle
      state_d    = ST_ARMED;
      wr_ptr_d   = 6'd0;
      post_cnt_d = 7'd0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (bus.sample_valid_i) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 6'd1;
            // a trigger only counts when it lands on a valid sample
            if (bus.trig_i) begin
              trig_pos_d = wr_ptr_q;
              post_cnt_d = 7'd1;
              state_d    = (POST_TRIG_C == 7'd1) ? ST_DONE : ST_TRIGGERED;
            end
          end
        end
        ST_TRIGGERED: begin
          if (bus.sample_valid_i) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 6'd1;
            if (post_cnt_q != 7'h7f) begin
              post_cnt_d = post_cnt_q + 7'd1;
            end
            if (post_cnt_q + 7'd1 == POST_TRIG_C) begin
              state_d = ST_DONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // No reset on the array: captured data survives a reset.
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) begin
      mem_q[wr_ptr_q] <= bus.sample_i;
    end
  end

  // Non-blocking read of the pre-write word gives old data on a collision.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_data_q <= 32'd0;
    end else begin
      mem_data_q <= mem_q[bus.mem_addr_i];
    end
  end

  assign bus.mem_data_o = mem_data_q;
  assign bus.busy_o     = (state_q == ST_ARMED) || (state_q == ST_TRIGGERED);
  assign bus.done_o     = (state_q == ST_DONE);
  assign bus.trig_pos_o = trig_pos_q;

endmodule

// File: tb/tb_capture_sram.sv
// tb/tb_capture_sram.sv - Directed bench for capture_sram with a reference model.
module tb_capture_sram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  capture_sram_if if0 ();
  capture_sram_if if1 ();

  logic        rst_q  [2];
  logic        arm_q  [2];
  logic        trig_q [2];
  logic        val_q  [2];
  logic [31:0] smp_q  [2];
  logic [5:0]  addr_q [2];

  logic        busy_w [2];
  logic        done_w [2];
  logic [5:0]  tpos_w [2];
  logic [31:0] data_w [2];

  assign if0.mem_addr_i     = addr_q[0];
  assign if0.sample_i       = smp_q[0];
  assign if0.sample_valid_i = val_q[0];
  assign if0.arm_i          = arm_q[0];
  assign if0.trig_i         = trig_q[0];
  assign if1.mem_addr_i     = addr_q[1];
  assign if1.sample_i       = smp_q[1];
  assign if1.sample_valid_i = val_q[1];
  assign if1.arm_i          = arm_q[1];
  assign if1.trig_i         = trig_q[1];

  assign busy_w[0] = if0.busy_o;
  assign done_w[0] = if0.done_o;
  assign tpos_w[0] = if0.trig_pos_o;
  assign data_w[0] = if0.mem_data_o;
  assign busy_w[1] = if1.busy_o;
  assign done_w[1] = if1.done_o;
  assign tpos_w[1] = if1.trig_pos_o;
  assign data_w[1] = if1.mem_data_o;

  capture_sram #(.POST_TRIG(4)) dut0 (.clk_i(clk), .rst_i(rst_q[0]), .bus(if0.slave));
  capture_sram #(.POST_TRIG(1)) dut1 (.clk_i(clk), .rst_i(rst_q[1]), .bus(if1.slave));

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Reference model: capture phase as an integer, buffer as a plain array.
  localparam int M_IDLE = 0, M_ARMED = 1, M_TRIG = 2, M_DONE = 3;
  bit          m_ok   [2];
  int          m_mode [2];
  int          m_ptr  [2];
  int          m_cnt  [2];
  int          m_tpos [2];
  logic [31:0] m_mem  [2][64];
  bit          m_memv [2][64];
  logic [31:0] m_rd   [2];
  bit          m_rdk  [2];

  function automatic int post_trig(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic model_step(input int k);
    if (rst_q[k]) begin
      m_ok[k]   = 1'b1;
      m_mode[k] = M_IDLE;
      m_ptr[k]  = 0;
      m_cnt[k]  = 0;
      m_tpos[k] = 0;
      m_rd[k]   = 32'd0;
      m_rdk[k]  = 1'b1;
    end else if (m_ok[k]) begin
      m_rd[k]  = m_mem[k][addr_q[k]];
      m_rdk[k] = m_memv[k][addr_q[k]];
      if (arm_q[k]) begin
        m_mode[k] = M_ARMED;
        m_ptr[k]  = 0;
        m_cnt[k]  = 0;
      end else if ((m_mode[k] == M_ARMED || m_mode[k] == M_TRIG) && val_q[k]) begin
        m_mem[k][m_ptr[k]]  = smp_q[k];
        m_memv[k][m_ptr[k]] = 1'b1;
        if (m_mode[k] == M_ARMED && trig_q[k]) begin
          m_tpos[k] = m_ptr[k];
          m_cnt[k]  = 1;
          m_mode[k] = (m_cnt[k] >= post_trig(k)) ? M_DONE : M_TRIG;
        end else if (m_mode[k] == M_TRIG) begin
          m_cnt[k]  = m_cnt[k] + 1;
          m_mode[k] = (m_cnt[k] >= post_trig(k)) ? M_DONE : M_TRIG;
        end
        m_ptr[k] = (m_ptr[k] + 1) % 64;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_ok[k]) begin
        check("busy", k, {31'd0, busy_w[k]},
              {31'd0, (m_mode[k] == M_ARMED || m_mode[k] == M_TRIG)});
        check("done", k, {31'd0, done_w[k]}, {31'd0, (m_mode[k] == M_DONE)});
        check("trig_pos", k, {26'd0, tpos_w[k]}, 32'(m_tpos[k]));
        if (m_rdk[k]) check("mem_data", k, data_w[k], m_rd[k]);
      end
    end
  end

  task automatic step(input int k, input logic r, input logic a, input logic t,
                      input logic v, input logic [31:0] d);
    @(negedge clk);
    rst_q[k]  = r;
    arm_q[k]  = a;
    trig_q[k] = t;
    val_q[k]  = v;
    smp_q[k]  = d;
  endtask

  task automatic rd(input int k, input logic [5:0] a, input logic [31:0] exp,
                    input string name);
    step(k, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    addr_q[k] = a;
    @(negedge clk);
    #1;
    check(name, k, data_w[k], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_q[k] = 1'b1; arm_q[k] = 1'b0; trig_q[k] = 1'b0;
      val_q[k] = 1'b0; smp_q[k] = 32'd0; addr_q[k] = 6'd0;
    end
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_busy", k, {31'd0, busy_w[k]}, 32'd0);
      check("rst_done", k, {31'd0, done_w[k]}, 32'd0);
      check("rst_tpos", k, {26'd0, tpos_w[k]}, 32'd0);
      check("rst_data", k, data_w[k], 32'd0);
      rst_q[k] = 1'b0;
    end

    // basic capture, POST_TRIG=4, trigger on 0x105
    step(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, (i == 5), 1, 32'h100 + 32'(i));
      if (i == 8) begin
        #1;
        check("done_before_last", 0, {31'd0, done_w[0]}, 32'd0);
      end
    end
    #1;
    check("basic_done", 0, {31'd0, done_w[0]}, 32'd1);
    check("basic_tpos", 0, {26'd0, tpos_w[0]}, 32'd5);
    for (int a = 5; a <= 8; a++) rd(0, 6'(a), 32'h100 + 32'(a), "basic_read");

    // wrap-around, POST_TRIG=1, trigger on sample 69 (pointer 5)
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 70; i++) step(1, 0, 0, (i == 69), 1, 32'(i));
    step(1, 0, 0, 0, 1, 32'd70);
    #1;
    check("wrap_done", 1, {31'd0, done_w[1]}, 32'd1);
    check("wrap_tpos", 1, {26'd0, tpos_w[1]}, 32'd5);
    rd(1, 6'd5, 32'd69, "wrap_mem5");
    rd(1, 6'd0, 32'd64, "wrap_mem0");
    rd(1, 6'd6, 32'd6, "wrap_mem6");

    // trigger gating: arm+trig in IDLE, trig without valid in ARMED
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 32'hAAAA);
    step(0, 0, 0, 1, 0, 0);
    #1;
    check("gate_busy", 0, {31'd0, busy_w[0]}, 32'd1);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, (i == 2), 1, 32'h200 + 32'(i));
    #1;
    check("gate_tpos", 0, {26'd0, tpos_w[0]}, 32'd2);
    check("gate_done", 0, {31'd0, done_w[0]}, 32'd0);

    // re-arm while TRIGGERED; arm-cycle sample must not be written
    step(0, 0, 1, 0, 1, 32'hBAD);
    step(0, 0, 0, 0, 0, 0);
    #1;
    check("rearm_busy", 0, {31'd0, busy_w[0]}, 32'd1);
    check("rearm_done", 0, {31'd0, done_w[0]}, 32'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, (i == 1), 1, 32'h300 + 32'(i));
    step(0, 0, 0, 0, 0, 0);
    #1;
    check("rearm_done2", 0, {31'd0, done_w[0]}, 32'd1);
    check("rearm_tpos", 0, {26'd0, tpos_w[0]}, 32'd1);
    rd(0, 6'd0, 32'h300, "rearm_mem0");
    rd(0, 6'd4, 32'h304, "rearm_mem4");
    rd(0, 6'd5, 32'h105, "rearm_mem5");

    // read/write collision on address 3
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h0);
    step(0, 0, 0, 0, 1, 32'h1);
    step(0, 0, 0, 0, 1, 32'h2);
    step(0, 0, 0, 0, 1, 32'hBEEF);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h10);
    step(0, 0, 0, 0, 1, 32'h11);
    step(0, 0, 0, 0, 1, 32'h12);
    step(0, 0, 0, 0, 1, 32'hDEAD);
    addr_q[0] = 6'd3;
    step(0, 0, 0, 0, 0, 0);
    #1;
    check("collide_old", 0, data_w[0], 32'hBEEF);
    step(0, 0, 0, 0, 0, 0);
    #1;
    check("collide_new", 0, data_w[0], 32'hDEAD);

    // reset in TRIGGERED; the sample alongside reset must not be written
    step(0, 0, 0, 1, 1, 32'h400);
    step(0, 1, 0, 0, 1, 32'h999);
    #1;
    check("pre_rst_busy", 0, {31'd0, busy_w[0]}, 32'd1);
    step(0, 0, 0, 0, 0, 0);
    #1;
    check("mid_rst_busy", 0, {31'd0, busy_w[0]}, 32'd0);
    check("mid_rst_done", 0, {31'd0, done_w[0]}, 32'd0);
    check("mid_rst_tpos", 0, {26'd0, tpos_w[0]}, 32'd0);
    check("mid_rst_data", 0, data_w[0], 32'd0);
    rd(0, 6'd4, 32'h400, "rst_keep4");
    rd(0, 6'd5, 32'h105, "rst_keep5");
    rd(0, 6'd3, 32'hDEAD, "rst_keep3");

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/capture_sram.md
CAPTURE_SRAM -- requirements
Module: capture_sram

Interface
REQ-001 The block SHALL have parameter POST_TRIG, default 32, meaning the number of samples written after and including the trigger sample, legal range 1..64.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock for all logic.
REQ-003 The block SHALL have port rst_i, input, 1, the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port mem_addr_i, input, 6 ([7:2]), the word read address driven by the upstream read-only SRAM bus.
REQ-005 The block SHALL have port mem_data_o, output, 32, the registered read data returned to the SRAM bus.
REQ-006 The block SHALL have port sample_i, input, 32, the capture data word.
REQ-007 The block SHALL have port sample_valid_i, input, 1, which qualifies sample_i in the current cycle.
REQ-008 The block SHALL have port arm_i, input, 1, a one-cycle pulse that starts a capture.
REQ-009 The block SHALL have port trig_i, input, 1, the trigger level, sampled each cycle.
REQ-010 The block SHALL have port busy_o, output, 1, which is high in states ARMED and TRIGGERED.
REQ-011 The block SHALL have port done_o, output, 1, which is high in state DONE.
REQ-012 The block SHALL have port trig_pos_o, output, 6, the word address of the trigger sample.

Function
REQ-013 Storage SHALL be 64 x 32-bit words, single write port and single read port, both clocked on clk_i.
REQ-014 The read port SHALL register mem[mem_addr_i] into mem_data_o every cycle, giving exactly 1 cycle latency, so that data is valid in the cycle after the address, matching the upstream rack timing.
REQ-015 A read and a write to the same address in the same cycle SHALL return the old (pre-write) data.
REQ-016 The FSM SHALL have states IDLE, ARMED, TRIGGERED and DONE.
REQ-017 In IDLE, arm_i SHALL cause a transition to ARMED with wr_ptr cleared to 0; trig_i SHALL be ignored, including when it is coincident with arm_i.
REQ-018 In ARMED, each cycle with sample_valid_i=1 SHALL write sample_i to mem[wr_ptr] and increment wr_ptr modulo 64, wrapping from 63 to 0.
REQ-019 In ARMED, trig_i=1 together with sample_valid_i=1 SHALL write that sample, set trig_pos_o to the wr_ptr used for that write, set post_cnt to 1, and move to TRIGGERED.
REQ-020 In ARMED, trig_i=1 with sample_valid_i=0 SHALL be ignored, so that a trigger is taken only on a valid sample.
REQ-021 In TRIGGERED, each valid sample SHALL be written as in REQ-018 and increment post_cnt, and trig_i SHALL be ignored.
REQ-022 The block SHALL move to DONE in the cycle after the write that makes post_cnt equal POST_TRIG; when POST_TRIG=1 it SHALL go directly from ARMED to DONE.
REQ-023 In DONE, no writes SHALL occur and done_o SHALL be 1.
REQ-024 In DONE, arm_i SHALL return the block to ARMED with wr_ptr=0 and done_o=0 on the next cycle.
REQ-025 In ARMED or TRIGGERED, arm_i SHALL restart the capture: state ARMED, wr_ptr=0, post_cnt=0, with no write in that cycle.
REQ-026 post_cnt SHALL be 7 bits wide and SHALL NOT wrap.
REQ-027 Memory contents SHALL persist across states; the read port SHALL operate in all states.

Reset
REQ-028 While rst_i=1 at a clk_i edge, the block SHALL set state=IDLE, wr_ptr=0, post_cnt=0, trig_pos_o=0, mem_data_o=0, busy_o=0 and done_o=0.
REQ-029 Reset SHALL NOT clear memory contents.
REQ-030 Reset SHALL take priority over arm_i, trig_i and sample_valid_i.
REQ-031 Reset asserted mid-capture SHALL abort the capture without any write in that cycle.

Verification
REQ-032 The bench SHALL cover basic capture: POST_TRIG=4, arm, samples 0x100..0x109, trig on 0x105 -> done_o rises after 0x108 is written, trig_pos_o=5, and reading addr 5..8 returns 0x105..0x108, each one cycle after its address.
REQ-033 The bench SHALL cover wrap-around: arm, 70 valid samples 0..69, trig on 69 with POST_TRIG=1 -> trig_pos_o=5, mem[5]=69, mem[0]=64, mem[6]=6.
REQ-034 The bench SHALL cover trigger gating: trig_i=1 with sample_valid_i=0 in ARMED -> state stays ARMED; trig_i with arm_i in IDLE -> ARMED, not TRIGGERED.
REQ-035 The bench SHALL cover re-arm: arm_i pulse in TRIGGERED after 2 post samples -> ARMED, wr_ptr=0, busy_o=1, done_o=0, and a later trigger completes normally.
REQ-036 The bench SHALL cover read/write collision: read addr 3 in the same cycle as a write of 0xDEAD to 3 over 0xBEEF -> mem_data_o=0xBEEF, then 0xDEAD on the next read of addr 3.
REQ-037 The bench SHALL cover reset mid-capture: rst_i pulse in TRIGGERED -> IDLE, all outputs 0, previously written words still readable.
